// File: rtl/idli_utx_m.sv
// idli_utx_m: UART transmit stage for idli.
// Words from EX arrive as four 4-bit slices over one sync-counter period.
// They are queued in a small FIFO, and each word is sent as two frames,
// low byte first.
// Optional build macro: IDLI_UTX_PARITY_EN gives 8E1 frames instead of 8N1.
module idli_utx_m #(
    parameter int DEPTH    = 4,
    parameter int BAUD_DIV = 4
) (
    input  logic       i_utx_gck,
    input  logic       i_utx_rst_n,
    input  logic [1:0] i_utx_ctr,
    input  logic       i_utx_vld,
    input  logic [3:0] i_utx_data,
    output logic       o_utx_full,
    output logic       o_utx_empty,
    output logic       o_utx_ovf,
    output logic       o_utx_tx
);

    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
`ifdef IDLI_UTX_PARITY_EN
        , ST_PARITY
`endif
    } state_t;

    logic              wr_act;
    logic              ovf_pend;
    logic [11:0]       asm_q;
    logic [15:0]       fifo_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_nxt;
    logic              full_q;
    logic              empty_q;

    state_t            state;
    state_t            state_nxt;
    logic [BAUD_W-1:0] baud_q;
    logic [BAUD_W-1:0] baud_nxt;
    logic [2:0]        bit_idx;
    logic [2:0]        bit_nxt;
    logic              byte_sel;
    logic              sel_nxt;

    logic              commit;
    logic              pop;
    logic              baud_last;
    logic [15:0]       head_word;
    logic [7:0]        cur_byte;
    logic              tx_c;

    // The final slice is taken straight from the bus, so the word commits on the edge that ends ctr==3.
    assign commit    = wr_act && (i_utx_ctr == 2'd3);
    assign baud_last = (baud_q == BAUD_LAST);
    assign pop       = (state == ST_STOP) && baud_last && byte_sel;
    assign head_word = fifo_mem[rd_ptr];
    assign cur_byte  = byte_sel ? head_word[15:8] : head_word[7:0];

    // The write decision is made once per period, at ctr==0, and the slices are gathered into the assembly register.
    always_ff @(posedge i_utx_gck or negedge i_utx_rst_n) begin
        if (!i_utx_rst_n) begin
            wr_act   <= 1'b0;
            ovf_pend <= 1'b0;
            asm_q    <= '0;
        end else begin
            unique case (i_utx_ctr)
                2'd0: begin
                    wr_act      <= i_utx_vld && !full_q;
                    ovf_pend    <= i_utx_vld && full_q;
                    asm_q[3:0]  <= i_utx_data;
                end
                2'd1:    asm_q[7:4]  <= i_utx_data;
                2'd2:    asm_q[11:8] <= i_utx_data;
                default: ;
            endcase
        end
    end

    // The FIFO storage has no reset; entries only become visible once they are counted.
    always_ff @(posedge i_utx_gck) begin
        if (commit) begin
            fifo_mem[wr_ptr] <= {i_utx_data, asm_q};
        end
    end

    // Occupancy changes only when exactly one of commit or pop happens.
    always_comb begin
        count_nxt = count;
        if (commit && !pop) begin
            count_nxt = count + CNT_ONE;
        end else if (!commit && pop) begin
            count_nxt = count - CNT_ONE;
        end
    end

    // This block holds the pointers, the count and the registered status flags.
    always_ff @(posedge i_utx_gck or negedge i_utx_rst_n) begin
        if (!i_utx_rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (commit) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count   <= count_nxt;
            full_q  <= (count_nxt == CNT_FULL);
            empty_q <= (count_nxt == '0) && (state_nxt == ST_IDLE);
        end
    end

    // This is the transmitter state register; reset returns the line to idle-high at once.
    always_ff @(posedge i_utx_gck or negedge i_utx_rst_n) begin
        if (!i_utx_rst_n) begin
            state    <= ST_IDLE;
            baud_q   <= '0;
            bit_idx  <= '0;
            byte_sel <= 1'b0;
        end else begin
            state    <= state_nxt;
            baud_q   <= baud_nxt;
            bit_idx  <= bit_nxt;
            byte_sel <= sel_nxt;
        end
    end

    // Frame sequencing: each state is held for BAUD_DIV cycles, and the two bytes of a word are sent back to back.
    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_q;
        bit_nxt   = bit_idx;
        sel_nxt   = byte_sel;
        tx_c      = 1'b1;
        unique case (state)
            ST_IDLE: begin
                tx_c = 1'b1;
                if (count != '0) begin
                    state_nxt = ST_START;
                    sel_nxt   = 1'b0;
                    baud_nxt  = '0;
                end
            end
            ST_START: begin
                tx_c = 1'b0;
                if (baud_last) begin
                    state_nxt = ST_DATA;
                    bit_nxt   = '0;
                    baud_nxt  = '0;
                end else begin
                    baud_nxt = baud_q + BAUD_ONE;
                end
            end
            ST_DATA: begin
                tx_c = cur_byte[bit_idx];
                if (baud_last) begin
                    baud_nxt = '0;
                    if (bit_idx == 3'd7) begin
`ifdef IDLI_UTX_PARITY_EN
                        state_nxt = ST_PARITY;
`else
                        state_nxt = ST_STOP;
`endif
                    end else begin
                        bit_nxt = bit_idx + 3'd1;
                    end
                end else begin
                    baud_nxt = baud_q + BAUD_ONE;
                end
            end
`ifdef IDLI_UTX_PARITY_EN
            ST_PARITY: begin
                tx_c = ^cur_byte;
                if (baud_last) begin
                    state_nxt = ST_STOP;
                    baud_nxt  = '0;
                end else begin
                    baud_nxt = baud_q + BAUD_ONE;
                end
            end
`endif
            ST_STOP: begin
                tx_c = 1'b1;
                if (baud_last) begin
                    baud_nxt = '0;
                    if (!byte_sel) begin
                        state_nxt = ST_START;
                        sel_nxt   = 1'b1;
                    end else if (count_nxt != '0) begin
                        state_nxt = ST_START;
                        sel_nxt   = 1'b0;
                    end else begin
                        state_nxt = ST_IDLE;
                        sel_nxt   = 1'b0;
                    end
                end else begin
                    baud_nxt = baud_q + BAUD_ONE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign o_utx_tx    = tx_c;
    assign o_utx_full  = full_q;
    assign o_utx_empty = empty_q;
    assign o_utx_ovf   = ovf_pend && (i_utx_ctr == 2'd3);

endmodule
